// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero register, optional same-cycle
// write-to-read bypass and a per-register busy scoreboard for issue tracking.
module regfile_mp #(
   parameter  int WIDTH     = 64,
   parameter  int DEPTH     = 32,
   parameter  int NUM_READ  = 2,
   parameter  int NUM_WRITE = 1,
   parameter  int ZERO_REG  = 31,
   parameter  int BYPASS    = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [AW-1:0]    readReg   [NUM_READ],
   output logic [WIDTH-1:0] readData  [NUM_READ],
   output logic             readBusy  [NUM_READ],
   input  logic [AW-1:0]    writeReg  [NUM_WRITE],
   input  logic [WIDTH-1:0] writeData [NUM_WRITE],
   input  logic             regWrEn   [NUM_WRITE],
   input  logic             busySet,
   input  logic [AW-1:0]    busyReg,
   output logic             anyBusy
);

   logic [WIDTH-1:0] mem   [DEPTH];
   logic [WIDTH-1:0] wrVal [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] wrHit;
   logic [DEPTH-1:0] setHit;

   // Per-register write decode; later ports override earlier ones so the
   // highest enabled port index wins. Out-of-range addresses match nothing.
   always_comb begin
      wrHit  = '0;
      setHit = '0;
      for (int d = 0; d < DEPTH; d++) begin
         wrVal[d] = '0;
         if (d != ZERO_REG) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
               if (regWrEn[w] && (writeReg[w] == AW'(d))) begin
                  wrHit[d] = 1'b1;
                  wrVal[d] = writeData[w];
               end
            end
            setHit[d] = busySet && (busyReg == AW'(d));
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
         busy <= '0;
      end else begin
         for (int d = 0; d < DEPTH; d++) begin
            if (wrHit[d]) mem[d] <= wrVal[d];
         end
         // A new producer issued in the same cycle outranks the retiring write.
         busy <= (busy & ~wrHit) | setHit;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_READ; r++) begin
         readData[r] = '0;
         readBusy[r] = 1'b0;
         if (reset_n) begin
            for (int d = 0; d < DEPTH; d++) begin
               if ((d != ZERO_REG) && (readReg[r] == AW'(d))) begin
                  readData[r] = ((BYPASS != 0) && wrHit[d]) ? wrVal[d] : mem[d];
                  readBusy[r] = busy[d] && !((BYPASS != 0) && wrHit[d] && !setHit[d]);
               end
            end
         end
      end
   end

   assign anyBusy = reset_n && (|busy);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances share one stimulus set
// (bypass 32-entry, registered 32-entry, bypass 24-entry with X0 as zero).
module tb_regfile_mp;

   logic        clk;
   logic        reset_n;
   logic [4:0]  readReg   [4];
   logic [4:0]  writeReg  [2];
   logic [63:0] writeData [2];
   logic        regWrEn   [2];
   logic        busySet;
   logic [4:0]  busyReg;

   logic [63:0] rdA [4];
   logic        rbA [4];
   logic        anyA;
   logic [63:0] rdB [4];
   logic        rbB [4];
   logic        anyB;
   logic [63:0] rdC [4];
   logic        rbC [4];
   logic        anyC;

   int nChecks = 0;
   int nPass   = 0;

   regfile_mp #(.WIDTH(64), .DEPTH(32), .NUM_READ(4), .NUM_WRITE(2), .ZERO_REG(31), .BYPASS(1)) dutA (
      .clk(clk), .reset_n(reset_n), .readReg(readReg), .readData(rdA), .readBusy(rbA),
      .writeReg(writeReg), .writeData(writeData), .regWrEn(regWrEn),
      .busySet(busySet), .busyReg(busyReg), .anyBusy(anyA));

   regfile_mp #(.WIDTH(64), .DEPTH(32), .NUM_READ(4), .NUM_WRITE(2), .ZERO_REG(31), .BYPASS(0)) dutB (
      .clk(clk), .reset_n(reset_n), .readReg(readReg), .readData(rdB), .readBusy(rbB),
      .writeReg(writeReg), .writeData(writeData), .regWrEn(regWrEn),
      .busySet(busySet), .busyReg(busyReg), .anyBusy(anyB));

   regfile_mp #(.WIDTH(64), .DEPTH(24), .NUM_READ(4), .NUM_WRITE(2), .ZERO_REG(0), .BYPASS(1)) dutC (
      .clk(clk), .reset_n(reset_n), .readReg(readReg), .readData(rdC), .readBusy(rbC),
      .writeReg(writeReg), .writeData(writeData), .regWrEn(regWrEn),
      .busySet(busySet), .busyReg(busyReg), .anyBusy(anyC));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pat(input int i);
      return 64'(i) * 64'h0000010204080001;
   endfunction

   task automatic idle();
      for (int w = 0; w < 2; w++) begin
         regWrEn[w]   = 1'b0;
         writeReg[w]  = '0;
         writeData[w] = '0;
      end
      busySet = 1'b0;
      busyReg = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      for (int r = 0; r < 4; r++) readReg[r] = 5'(r);
      #1;
      nChecks++;
      if (rdA[0] !== 64'h0 || rbA[0] !== 1'b0 || anyA !== 1'b0)
         $display("FAIL reset_initial: rd=%h busy=%b any=%b want 0/0/0", rdA[0], rbA[0], anyA);
      else nPass++;
      #2 reset_n = 1'b1;
      step();
      for (int i = 0; i <= 30; i += 2) begin
         regWrEn[0] = 1'b1; writeReg[0] = 5'(i);     writeData[0] = pat(i);
         regWrEn[1] = 1'b1; writeReg[1] = 5'(i + 1); writeData[1] = pat(i + 1);
         busySet = (i == 30); busyReg = 5'd20;
         step();
      end
      idle();
      readReg[0] = 5'd10; readReg[1] = 5'd20; readReg[2] = 5'd30; readReg[3] = 5'd12;
      #1;
      nChecks++;
      if (rdB[0] !== pat(10) || anyA !== 1'b1)
         $display("FAIL reset_prefill: X10=%h any=%b want %h/1", rdB[0], anyA, pat(10));
      else nPass++;
      // Write in flight to X12 when reset drops mid-cycle; it must be lost.
      regWrEn[0] = 1'b1; writeReg[0] = 5'd12; writeData[0] = 64'hFF;
      #1 reset_n = 1'b0;
      #1;
      nChecks++;
      if (rdA[0] !== 64'h0 || rdA[1] !== 64'h0 || rdA[2] !== 64'h0 || rdA[3] !== 64'h0 || rdB[0] !== 64'h0)
         $display("FAIL reset_async_data: A=%h %h %h %h B=%h want 0", rdA[0], rdA[1], rdA[2], rdA[3], rdB[0]);
      else nPass++;
      nChecks++;
      if (anyA !== 1'b0 || anyB !== 1'b0 || rbA[1] !== 1'b0)
         $display("FAIL reset_async_busy: anyA=%b anyB=%b rb=%b want 0", anyA, anyB, rbA[1]);
      else nPass++;
      step();
      idle();
      #2 reset_n = 1'b1;
      step();
      nChecks++;
      if (rdB[3] !== 64'h0 || rdB[0] !== 64'h0)
         $display("FAIL reset_lost_write: X12=%h X10=%h want 0", rdB[3], rdB[0]);
      else nPass++;
   endtask

   task automatic test_pattern();
      for (int i = 0; i <= 30; i += 2) begin
         logic [63:0] expHi;
         logic [63:0] expPrev;
         regWrEn[0] = 1'b1; writeReg[0] = 5'(i);     writeData[0] = pat(i);
         regWrEn[1] = 1'b1; writeReg[1] = 5'(i + 1); writeData[1] = pat(i + 1);
         readReg[0] = 5'(i); readReg[1] = 5'(i + 1);
         readReg[2] = (i == 0) ? 5'd31 : 5'(i - 1);
         readReg[3] = 5'(i + 1);
         expHi   = (i + 1 == 31) ? 64'h0 : pat(i + 1);
         expPrev = (i == 0) ? 64'h0 : pat(i - 1);
         #1;
         nChecks++;
         if (rdA[0] !== pat(i) || rdA[1] !== expHi || rdA[2] !== expPrev || rdA[3] !== expHi)
            $display("FAIL pattern_bypass i=%0d: %h %h %h %h want %h %h %h", i,
                     rdA[0], rdA[1], rdA[2], rdA[3], pat(i), expHi, expPrev);
         else nPass++;
         nChecks++;
         if (rdB[0] !== 64'h0 || rdB[2] !== expPrev)
            $display("FAIL pattern_registered i=%0d: cur=%h prev=%h want 0 %h", i, rdB[0], rdB[2], expPrev);
         else nPass++;
         step();
      end
      idle();
   endtask

   task automatic test_dual_write();
      regWrEn[0] = 1'b1; writeReg[0] = 5'd5; writeData[0] = 64'h11;
      regWrEn[1] = 1'b1; writeReg[1] = 5'd5; writeData[1] = 64'h22;
      readReg[0] = 5'd5;
      #1;
      nChecks++;
      if (rdA[0] !== 64'h22 || rdB[0] !== pat(5))
         $display("FAIL dual_write_same_cycle: A=%h B=%h want 22 %h", rdA[0], rdB[0], pat(5));
      else nPass++;
      step();
      idle();
      #1;
      nChecks++;
      if (rdA[0] !== 64'h22 || rdB[0] !== 64'h22)
         $display("FAIL dual_write_stored: A=%h B=%h want 22", rdA[0], rdB[0]);
      else nPass++;
      step();
   endtask

   task automatic test_bypass();
      regWrEn[0] = 1'b1; writeReg[0] = 5'd7; writeData[0] = 64'hDEAD;
      readReg[0] = 5'd7;
      #1;
      nChecks++;
      if (rdA[0] !== 64'hDEAD)
         $display("FAIL bypass_on: got %h want dead", rdA[0]);
      else nPass++;
      nChecks++;
      if (rdB[0] !== pat(7))
         $display("FAIL bypass_off_old: got %h want %h", rdB[0], pat(7));
      else nPass++;
      step();
      idle();
      #1;
      nChecks++;
      if (rdB[0] !== 64'hDEAD || rdA[0] !== 64'hDEAD)
         $display("FAIL bypass_off_next: B=%h A=%h want dead", rdB[0], rdA[0]);
      else nPass++;
      step();
   endtask

   task automatic test_zero_reg();
      regWrEn[0] = 1'b1; writeReg[0] = 5'd31; writeData[0] = 64'hA0;
      busySet = 1'b1; busyReg = 5'd31;
      readReg[0] = 5'd31;
      #1;
      nChecks++;
      if (rdA[0] !== 64'h0 || rbA[0] !== 1'b0)
         $display("FAIL zero_same_cycle: rd=%h busy=%b want 0/0", rdA[0], rbA[0]);
      else nPass++;
      step();
      idle();
      #1;
      nChecks++;
      if (rdA[0] !== 64'h0 || rdB[0] !== 64'h0 || rbA[0] !== 1'b0 || rbB[0] !== 1'b0)
         $display("FAIL zero_next_cycle: A=%h B=%h rbA=%b rbB=%b want 0", rdA[0], rdB[0], rbA[0], rbB[0]);
      else nPass++;
      nChecks++;
      if (anyA !== 1'b0 || anyB !== 1'b0)
         $display("FAIL zero_anybusy: A=%b B=%b want 0", anyA, anyB);
      else nPass++;
      step();
   endtask

   task automatic test_scoreboard();
      busySet = 1'b1; busyReg = 5'd3; readReg[0] = 5'd3;
      #1;
      nChecks++;
      if (rbA[0] !== 1'b0)
         $display("FAIL sb_before_set: got %b want 0", rbA[0]);
      else nPass++;
      step();
      busySet = 1'b0;
      #1;
      nChecks++;
      if (rbA[0] !== 1'b1 || rbB[0] !== 1'b1 || anyA !== 1'b1)
         $display("FAIL sb_set: rbA=%b rbB=%b any=%b want 1", rbA[0], rbB[0], anyA);
      else nPass++;
      regWrEn[0] = 1'b1; writeReg[0] = 5'd3; writeData[0] = 64'h33;
      #1;
      nChecks++;
      if (rbA[0] !== 1'b0 || rbB[0] !== 1'b1)
         $display("FAIL sb_clear_same_cycle: rbA=%b rbB=%b want 0 1", rbA[0], rbB[0]);
      else nPass++;
      step();
      idle();
      #1;
      nChecks++;
      if (rbA[0] !== 1'b0 || rbB[0] !== 1'b0 || anyA !== 1'b0 || anyB !== 1'b0)
         $display("FAIL sb_cleared: rbA=%b rbB=%b anyA=%b anyB=%b want 0", rbA[0], rbB[0], anyA, anyB);
      else nPass++;
      busySet = 1'b1; busyReg = 5'd3;
      step();
      regWrEn[0] = 1'b1; writeReg[0] = 5'd3; writeData[0] = 64'h34;
      busySet = 1'b1; busyReg = 5'd3;
      #1;
      nChecks++;
      if (rbA[0] !== 1'b1 || rbB[0] !== 1'b1)
         $display("FAIL sb_set_and_write_cycle: rbA=%b rbB=%b want 1", rbA[0], rbB[0]);
      else nPass++;
      step();
      idle();
      #1;
      nChecks++;
      if (rbA[0] !== 1'b1 || rbB[0] !== 1'b1 || anyA !== 1'b1 || rdB[0] !== 64'h34)
         $display("FAIL sb_set_wins: rbA=%b rbB=%b any=%b rd=%h want 1 1 1 34", rbA[0], rbB[0], anyA, rdB[0]);
      else nPass++;
      regWrEn[0] = 1'b1; writeReg[0] = 5'd3; writeData[0] = 64'h35;
      step();
      idle();
      #1;
      nChecks++;
      if (anyA !== 1'b0 || anyC !== 1'b0)
         $display("FAIL sb_final_clear: anyA=%b anyC=%b want 0", anyA, anyC);
      else nPass++;
      step();
   endtask

   task automatic test_nonpow2();
      regWrEn[0] = 1'b1; writeReg[0] = 5'd27; writeData[0] = 64'h55;
      regWrEn[1] = 1'b1; writeReg[1] = 5'd0;  writeData[1] = 64'h66;
      busySet = 1'b1; busyReg = 5'd27;
      readReg[0] = 5'd27; readReg[1] = 5'd0;
      #1;
      nChecks++;
      if (rdC[0] !== 64'h0 || rdC[1] !== 64'h0 || rbC[0] !== 1'b0)
         $display("FAIL np2_same_cycle: X27=%h X0=%h busy=%b want 0", rdC[0], rdC[1], rbC[0]);
      else nPass++;
      step();
      idle();
      #1;
      nChecks++;
      if (rdC[0] !== 64'h0 || rdC[1] !== 64'h0 || rbC[0] !== 1'b0 || anyC !== 1'b0)
         $display("FAIL np2_ignored: X27=%h X0=%h busy=%b any=%b want 0", rdC[0], rdC[1], rbC[0], anyC);
      else nPass++;
      regWrEn[0] = 1'b1; writeReg[0] = 5'd23; writeData[0] = 64'h77;
      readReg[2] = 5'd23;
      #1;
      nChecks++;
      if (rdC[2] !== 64'h77)
         $display("FAIL np2_top_bypass: got %h want 77", rdC[2]);
      else nPass++;
      step();
      idle();
      #1;
      nChecks++;
      if (rdC[2] !== 64'h77)
         $display("FAIL np2_top_stored: got %h want 77", rdC[2]);
      else nPass++;
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_dual_write();
      test_bypass();
      test_zero_reg();
      test_scoreboard();
      test_nonpow2();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
